// File: rtl/prog_loader_pkg.sv
// Shared constants for the boot-time program loader: state encodings and
// stream/frame parameters.
package prog_loader_pkg;

   // Stream byte width
   localparam int unsigned ByteW = 8;

   // FSM state encodings (4-bit)
   localparam logic [3:0] StIdle   = 4'd0;
   localparam logic [3:0] StCntHi  = 4'd1;
   localparam logic [3:0] StCntLo  = 4'd2;
   localparam logic [3:0] StDataHi = 4'd3;
   localparam logic [3:0] StDataLo = 4'd4;
   localparam logic [3:0] StWrite  = 4'd5;
   localparam logic [3:0] StCksum  = 4'd6;
   localparam logic [3:0] StDone   = 4'd7;
   localparam logic [3:0] StErr    = 4'd8;

   // A frame is valid when the modular byte sum, checksum included, hits this value
   localparam logic [ByteW-1:0] CksumGood = 8'h00;

   // States in which the loader takes a stream byte
   function automatic logic accepts_byte(input logic [3:0] st);
      return (st == StCntHi) || (st == StCntLo) || (st == StDataHi) ||
             (st == StDataLo) || (st == StCksum);
   endfunction

   // States from which a start pulse launches a new load
   function automatic logic start_ok(input logic [3:0] st);
      return (st == StIdle) || (st == StDone) || (st == StErr);
   endfunction

endpackage

// File: rtl/prog_loader_cksum.sv
// 8-bit modular checksum accumulator with clear, add-enable and a zero flag.
// zero_o reports whether the sum including the byte being added this cycle
// equals the good-frame value, so the FSM can decide on the checksum byte itself.
module prog_loader_cksum
   import prog_loader_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             add_i,
   input  logic [ByteW-1:0] byte_i,
   output logic             zero_o
);

   logic [ByteW-1:0] sum_q, sum_d, sum_inc;

   // Sum as it would stand after this cycle's byte
   always_comb begin
      sum_inc = sum_q + (add_i ? byte_i : '0);
      sum_d   = clr_i ? '0 : sum_inc;
      zero_o  = (sum_inc == CksumGood);
   end

   // Accumulator register
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream, assembles
// big-endian words, writes them to memory and releases the core from reset
// once the frame checksum verifies.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned DATAW    = 16,
   parameter int unsigned ADDRW    = 16,
   parameter int unsigned LOADBASE = 0,
   parameter int unsigned MAXWORDS = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [ByteW-1:0] in_data,
   output logic             in_ready,
   output logic             mem_wr,
   output logic [ADDRW-1:0] mem_addr,
   output logic [DATAW-1:0] mem_wrdata,
   output logic             cpu_reset,
   output logic             done,
   output logic             error
);

   localparam logic [16:0] MaxN = 17'(MAXWORDS);

   logic [3:0]       state_q, state_d;
   logic [15:0]      count_q, count_d;
   logic [15:0]      idx_q, idx_d;
   logic [7:0]       hi_q, hi_d;
   logic [ADDRW-1:0] addr_q, addr_d;
   logic [DATAW-1:0] wdata_q, wdata_d;
   logic             in_ready_q, mem_wr_q, cpu_reset_q, done_q, error_q;
   logic             xfer, cks_clr, cks_zero;
   logic [15:0]      n_word;

   assign xfer = in_valid & in_ready_q;

   prog_loader_cksum u_cksum (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (cks_clr),
      .add_i  (xfer),
      .byte_i (in_data),
      .zero_o (cks_zero)
   );

   // Next-state logic for the FSM, counters and write-port registers
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cks_clr = 1'b0;
      n_word  = {count_q[15:8], in_data};
      case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               state_d = StCntHi;
               idx_d   = '0;
               cks_clr = 1'b1;
            end
         end
         StCntHi: begin
            if (xfer) begin
               count_d[15:8] = in_data;
               state_d       = StCntLo;
            end
         end
         StCntLo: begin
            if (xfer) begin
               count_d = n_word;
               if ({1'b0, n_word} > MaxN) begin
                  state_d = StErr;
               end else if (n_word == '0) begin
                  state_d = StCksum;
               end else begin
                  state_d = StDataHi;
               end
            end
         end
         StDataHi: begin
            if (xfer) begin
               hi_d    = in_data;
               state_d = StDataLo;
            end
         end
         StDataLo: begin
            if (xfer) begin
               // Address wraps modulo the address width
               addr_d  = ADDRW'(LOADBASE) + ADDRW'(idx_q);
               wdata_d = DATAW'({hi_q, in_data});
               state_d = StWrite;
            end
         end
         StWrite: begin
            idx_d = idx_q + 16'd1;
            if (({1'b0, idx_q} + 17'd1) < {1'b0, count_q}) begin
               state_d = StDataHi;
            end else begin
               state_d = StCksum;
            end
         end
         StCksum: begin
            if (xfer) begin
               state_d = cks_zero ? StDone : StErr;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; outputs are decoded from the next state so
   // they line up with the state they describe
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         count_q     <= '0;
         idx_q       <= '0;
         hi_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         in_ready_q  <= 1'b0;
         mem_wr_q    <= 1'b0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         hi_q        <= hi_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         in_ready_q  <= accepts_byte(state_d);
         mem_wr_q    <= (state_d == StWrite);
         cpu_reset_q <= (state_d != StDone);
         done_q      <= (state_d == StDone);
         error_q     <= (state_d == StErr);
      end
   end

   assign in_ready   = in_ready_q;
   assign mem_wr     = mem_wr_q;
   assign mem_addr   = addr_q;
   assign mem_wrdata = wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of whole frames plus hand-written
// sequences for reset values, N = MAXWORDS, reload, ignored start and reset mid-load.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, mem_wr, cpu_reset, done, error;
   logic [15:0] mem_addr, mem_wrdata;

   int tests = 0;
   int fails = 0;

   prog_loader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wrdata (mem_wrdata),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   // Write monitor, sampled on the falling edge
   int          wr_n = 0;
   logic [15:0] mon_a [1024];
   logic [15:0] mon_d [1024];
   always @(negedge clk) begin
      if (mem_wr) begin
         if (wr_n < 1024) begin
            mon_a[wr_n] <= mem_addr;
            mon_d[wr_n] <= mem_wrdata;
         end
         wr_n <= wr_n + 1;
      end
   end

   typedef struct {
      string       name;
      int          nb;
      logic [7:0]  b [10];
      int          gap;
      int          nw;
      logic [15:0] a [2];
      logic [15:0] d [2];
      logic        dn;
      logic        er;
   } vec_t;

   vec_t v [7];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the transfer
   task automatic send_byte(input logic [7:0] b);
      int tmo = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && tmo < 50) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 50) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready got 0 expected 1 for byte %0h", b);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_vec(input int i);
      int base;
      base = wr_n;
      pulse_start();
      for (int j = 0; j < v[i].nb; j++) begin
         send_byte(v[i].b[j]);
         if (j != v[i].nb - 1) repeat (v[i].gap) @(negedge clk);
      end
      @(negedge clk);
      check({v[i].name, " writes"}, 32'(wr_n - base), 32'(v[i].nw));
      for (int k = 0; k < v[i].nw; k++) begin
         check({v[i].name, " addr"}, {16'd0, mon_a[base + k]}, {16'd0, v[i].a[k]});
         check({v[i].name, " data"}, {16'd0, mon_d[base + k]}, {16'd0, v[i].d[k]});
      end
      check({v[i].name, " done"}, {31'd0, done}, {31'd0, v[i].dn});
      check({v[i].name, " error"}, {31'd0, error}, {31'd0, v[i].er});
      check({v[i].name, " cpu_reset"}, {31'd0, cpu_reset}, {31'd0, ~v[i].dn});
      check({v[i].name, " in_ready"}, {31'd0, in_ready}, 32'd0);
   endtask

   initial begin
      int base;
      logic [7:0] w;

      v[0] = '{name: "nominal", nb: 7, gap: 0, nw: 2,
               b: '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00},
               a: '{16'd0, 16'd1}, d: '{16'h1234, 16'hABCD}, dn: 1'b1, er: 1'b0};
      v[1] = '{name: "bad_cksum", nb: 7, gap: 0, nw: 2,
               b: '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00, 8'h00, 8'h00},
               a: '{16'd0, 16'd1}, d: '{16'h1234, 16'hABCD}, dn: 1'b0, er: 1'b1};
      v[2] = '{name: "empty", nb: 3, gap: 0, nw: 0,
               b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               a: '{16'd0, 16'd0}, d: '{16'h0, 16'h0}, dn: 1'b1, er: 1'b0};
      v[3] = '{name: "oversize", nb: 2, gap: 0, nw: 0,
               b: '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               a: '{16'd0, 16'd0}, d: '{16'h0, 16'h0}, dn: 1'b0, er: 1'b1};
      v[4] = '{name: "stalled", nb: 7, gap: 3, nw: 2,
               b: '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00},
               a: '{16'd0, 16'd1}, d: '{16'h1234, 16'hABCD}, dn: 1'b1, er: 1'b0};
      v[5] = '{name: "empty_bad", nb: 3, gap: 1, nw: 0,
               b: '{8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               a: '{16'd0, 16'd0}, d: '{16'h0, 16'h0}, dn: 1'b0, er: 1'b1};
      // 01 + 80 + 7F = 0x100, checksum 00
      v[6] = '{name: "one_word", nb: 5, gap: 2, nw: 1,
               b: '{8'h00, 8'h01, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               a: '{16'd0, 16'd0}, d: '{16'h807F, 16'h0}, dn: 1'b1, er: 1'b0};

      // Reset values
      repeat (3) @(negedge clk);
      check("rst in_ready", {31'd0, in_ready}, 32'd0);
      check("rst mem_wr", {31'd0, mem_wr}, 32'd0);
      check("rst mem_addr", {16'd0, mem_addr}, 32'd0);
      check("rst mem_wrdata", {16'd0, mem_wrdata}, 32'd0);
      check("rst cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst error", {31'd0, error}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle in_ready", {31'd0, in_ready}, 32'd0);

      for (int i = 0; i < 7; i++) run_vec(i);

      // N = MAXWORDS: word i = {i, ~i}, each word sums to FF; header 01, checksum FF
      base = wr_n;
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         w = 8'(i);
         send_byte(w);
         send_byte(~w);
      end
      send_byte(8'hFF);
      @(negedge clk);
      check("max writes", 32'(wr_n - base), 32'd256);
      check("max first data", {16'd0, mon_d[base]}, 32'h00FF);
      check("max last addr", {16'd0, mon_a[base + 255]}, 32'd255);
      check("max last data", {16'd0, mon_d[base + 255]}, 32'hFF00);
      check("max done", {31'd0, done}, 32'd1);
      check("max cpu_reset", {31'd0, cpu_reset}, 32'd0);

      // Reload from DONE, then starts during DATA_HI are ignored
      base = wr_n;
      pulse_start();
      check("reload cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("reload done", {31'd0, done}, 32'd0);
      check("reload in_ready", {31'd0, in_ready}, 32'd1);
      send_byte(8'h00);
      send_byte(8'h01);
      pulse_start();
      check("ign start in_ready", {31'd0, in_ready}, 32'd1);
      check("ign start error", {31'd0, error}, 32'd0);
      // start coinciding with the hi-byte transfer
      start = 1'b1;
      send_byte(8'hAA);
      start = 1'b0;
      check("start+xfer in_ready", {31'd0, in_ready}, 32'd1);
      send_byte(8'h55);
      send_byte(8'h00);
      @(negedge clk);
      check("reload writes", 32'(wr_n - base), 32'd1);
      check("reload data", {16'd0, mon_d[base]}, 32'hAA55);
      check("reload addr", {16'd0, mon_a[base]}, 32'd0);
      check("reload fin done", {31'd0, done}, 32'd1);

      // Reset after the fourth byte of a nominal frame
      base = wr_n;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h12);
      send_byte(8'h34);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst in_ready", {31'd0, in_ready}, 32'd0);
      check("midrst cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("midrst mem_wr", {31'd0, mem_wr}, 32'd0);
      check("midrst done", {31'd0, done}, 32'd0);
      in_valid = 1'b1;
      in_data  = 8'hAB;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      check("midrst ignored in_ready", {31'd0, in_ready}, 32'd0);
      check("midrst writes", 32'(wr_n - base), 32'd1);
      check("midrst error", {31'd0, error}, 32'd0);
      run_vec(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
